// File: rtl/microsequencer_if.sv
// Microsequencer control/status bundle: next-address controls in, microaddress and stack status out.
// master = the control unit driving selects; slave = the sequencer itself.
interface microsequencer_if #(
  parameter int ADDR_WIDTH  = 9,
  parameter int STACK_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] Encoder_Address;
  logic [ADDR_WIDTH-1:0] Control_Register_Address;
  logic [2:0]            Next_State_Address_Select;
  logic                  Condition;
  logic                  Stall;
  logic [ADDR_WIDTH-1:0] Next_State_Address;
  logic                  Stack_Overflow;
  logic                  Stack_Underflow;
  logic [LEVEL_W-1:0]    Stack_Level;

  modport master (
    output Encoder_Address, Control_Register_Address, Next_State_Address_Select,
           Condition, Stall,
    input  Next_State_Address, Stack_Overflow, Stack_Underflow, Stack_Level
  );

  modport slave (
    input  Encoder_Address, Control_Register_Address, Next_State_Address_Select,
           Condition, Stall,
    output Next_State_Address, Stack_Overflow, Stack_Underflow, Stack_Level
  );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: registered microaddress with encoder/fetch/jump/increment/branch
// modes and a LIFO return-address stack with sticky overflow/underflow flags.
module microsequencer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int STACK_DEPTH = 4,
  parameter int FETCH_ADDR  = 1,
  parameter int RESET_ADDR  = 0
) (
  input logic            Clock,
  input logic            Reset,
  microsequencer_if.slave seq
);
  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    SEL_ENCODER = 3'b000,
    SEL_FETCH   = 3'b001,
    SEL_JUMP    = 3'b010,
    SEL_INC     = 3'b011,
    SEL_CALL    = 3'b100,
    SEL_RETURN  = 3'b101,
    SEL_BRANCH  = 3'b110,
    SEL_HOLD    = 3'b111
  } sel_e;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  addr_t              addr_q, addr_d, inc;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic               push, full, empty;
  logic [PTR_W-1:0]   push_idx, top_idx;
  addr_t              stack_mem [STACK_DEPTH];
  sel_e               sel;

  assign sel      = sel_e'(seq.Next_State_Address_Select);
  assign inc      = addr_q + addr_t'(1);
  assign full     = (level_q == LEVEL_W'(STACK_DEPTH));
  assign empty    = (level_q == '0);
  assign push_idx = PTR_W'(level_q);
  assign top_idx  = PTR_W'(level_q - LEVEL_W'(1));

  // NOTE: every variable gets its default before the case; a path that skips an
  // assignment in always_comb would otherwise infer a latch.
  always_comb begin
    addr_d  = addr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (!seq.Stall) begin
      unique case (sel)
        SEL_ENCODER: addr_d = seq.Encoder_Address;
        SEL_FETCH:   addr_d = addr_t'(FETCH_ADDR);
        SEL_JUMP:    addr_d = seq.Control_Register_Address;
        SEL_INC:     addr_d = inc;
        SEL_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            addr_d  = seq.Control_Register_Address;
            level_d = level_q + LEVEL_W'(1);
          end
        end
        SEL_RETURN: begin
          // Empty stack: entries are stale, so fall back to instruction fetch.
          if (empty) begin
            udf_d  = 1'b1;
            addr_d = addr_t'(FETCH_ADDR);
          end else begin
            addr_d  = stack_mem[top_idx];
            level_d = level_q - LEVEL_W'(1);
          end
        end
        SEL_BRANCH:  addr_d = seq.Condition ? seq.Control_Register_Address : inc;
        SEL_HOLD:    addr_d = addr_q;
        default:     addr_d = addr_q;
      endcase
    end
  end

  // NOTE: sequential state is assigned with <= so all registers sample the
  // pre-edge values together regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      addr_q  <= addr_t'(RESET_ADDR);
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: the stack array is deliberately not reset; clearing level_q makes every
  // entry unreachable, and leaving it out of reset lets it map to plain storage.
  always_ff @(posedge Clock) begin
    if (Reset && push) begin
      stack_mem[push_idx] <= inc;
    end
  end

  assign seq.Next_State_Address = addr_q;
  assign seq.Stack_Level        = level_q;
  assign seq.Stack_Overflow     = ovf_q;
  assign seq.Stack_Underflow    = udf_q;
endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer with hand-computed expected addresses,
// stack levels and flags at default parameters.
module tb_microsequencer;
  localparam int ADDR_WIDTH  = 9;
  localparam int STACK_DEPTH = 4;

  localparam logic [2:0] ENC = 3'b000, FET = 3'b001, JMP = 3'b010, INC = 3'b011;
  localparam logic [2:0] CAL = 3'b100, RET = 3'b101, BRA = 3'b110, HLD = 3'b111;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  microsequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH)) bus ();

  microsequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH),
    .FETCH_ADDR (1),
    .RESET_ADDR (0)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .seq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int addr, input int lvl,
                              input int ovf, input int udf);
    check({tag, ".addr"},  32'(bus.Next_State_Address), 32'(addr));
    check({tag, ".level"}, 32'(bus.Stack_Level),        32'(lvl));
    check({tag, ".ovf"},   32'(bus.Stack_Overflow),     32'(ovf));
    check({tag, ".udf"},   32'(bus.Stack_Underflow),    32'(udf));
  endtask

  // Apply one select for one rising edge; outputs are sampled 1ns after the edge.
  task automatic step(input logic [2:0] sel, input int cra);
    bus.Next_State_Address_Select = sel;
    bus.Control_Register_Address  = ADDR_WIDTH'(cra);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Stall = 1'b0;
    bus.Condition = 1'b0;
    bus.Encoder_Address = '0;
    bus.Control_Register_Address = '0;
    bus.Next_State_Address_Select = INC;
    @(negedge clk);

    // Reset then three increments
    step(INC, 0);                 expect_state("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(INC, 0);                 expect_state("inc1", 1, 0, 0, 0);
    step(INC, 0);                 expect_state("inc2", 2, 0, 0, 0);
    step(INC, 0);                 expect_state("inc3", 3, 0, 0, 0);
    step(INC, 0);
    step(INC, 0);                 expect_state("at5", 5, 0, 0, 0);

    // Call / increment / return
    step(CAL, 200);               expect_state("call200", 200, 1, 0, 0);
    step(INC, 0);                 expect_state("inc201", 201, 1, 0, 0);
    step(RET, 0);                 expect_state("ret6", 6, 0, 0, 0);
    step(CAL, 100);               expect_state("call100", 100, 1, 0, 0);
    step(RET, 0);                 expect_state("ret7", 7, 0, 0, 0);

    // Condition is ignored outside branch mode
    bus.Condition = 1'b1;
    step(INC, 300);               expect_state("cond_ign", 8, 0, 0, 0);
    bus.Condition = 1'b0;

    // Registered latency: a new select has no effect before the edge
    bus.Next_State_Address_Select = JMP;
    bus.Control_Register_Address  = 9'd10;
    #2;
    check("latency.pre", 32'(bus.Next_State_Address), 32'd8);
    step(JMP, 10);                expect_state("jmp10", 10, 0, 0, 0);

    // Branch not taken / taken
    step(BRA, 300);               expect_state("br_nt", 11, 0, 0, 0);
    step(JMP, 10);
    bus.Condition = 1'b1;
    step(BRA, 300);               expect_state("br_t", 300, 0, 0, 0);
    bus.Condition = 1'b0;

    // Stall freezes everything, including a call
    bus.Stall = 1'b1;
    bus.Encoder_Address = 9'd77;
    step(ENC, 0);                 expect_state("stall1", 300, 0, 0, 0);
    step(ENC, 0);                 expect_state("stall2", 300, 0, 0, 0);
    step(CAL, 50);                expect_state("stall_call", 300, 0, 0, 0);
    bus.Stall = 1'b0;

    // Wrap, encoder, fetch, hold
    step(JMP, 511);               expect_state("jmp511", 511, 0, 0, 0);
    step(INC, 0);                 expect_state("wrap", 0, 0, 0, 0);
    step(ENC, 0);                 expect_state("enc77", 77, 0, 0, 0);
    step(FET, 0);                 expect_state("fetch", 1, 0, 0, 0);
    step(HLD, 400);               expect_state("hold", 1, 0, 0, 0);

    // Nested calls, overflow, LIFO unwind, underflow
    step(JMP, 10);
    step(CAL, 20);                expect_state("nest1", 20, 1, 0, 0);
    step(CAL, 30);                expect_state("nest2", 30, 2, 0, 0);
    step(CAL, 35);                expect_state("nest3", 35, 3, 0, 0);
    step(CAL, 40);                expect_state("nest4", 40, 4, 0, 0);
    step(CAL, 50);                expect_state("ovf", 40, 4, 1, 0);
    step(RET, 0);                 expect_state("unw1", 36, 3, 1, 0);
    step(RET, 0);                 expect_state("unw2", 31, 2, 1, 0);
    step(RET, 0);                 expect_state("unw3", 21, 1, 1, 0);
    step(RET, 0);                 expect_state("unw4", 11, 0, 1, 0);
    step(RET, 0);                 expect_state("udf", 1, 0, 1, 1);
    step(JMP, 99);                expect_state("sticky", 99, 0, 1, 1);

    // Reset clears flags, then reset mid-call-chain with stall asserted
    rst_n = 1'b0;
    step(INC, 0);                 expect_state("reset2", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(CAL, 100);               expect_state("chain1", 100, 1, 0, 0);
    step(CAL, 120);               expect_state("chain2", 120, 2, 0, 0);
    rst_n = 1'b0;
    bus.Stall = 1'b1;
    step(RET, 0);                 expect_state("rst_stall", 0, 0, 0, 0);
    rst_n = 1'b1;
    bus.Stall = 1'b0;
    step(RET, 0);                 expect_state("post_rst_ret", 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, microstore address width.
REQ-002 Parameter: STACK_DEPTH, default 4, number of return-address stack entries (>=1).
REQ-003 Parameter: FETCH_ADDR, default 1, microaddress of the instruction Fetch state.
REQ-004 Parameter: RESET_ADDR, default 0, microaddress loaded on reset.
REQ-005 Port: Clock  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-006 Port: Reset  input  1  reset, synchronous, active-low.
REQ-007 Port: Encoder_Address  input  ADDR_WIDTH  opcode-decoded target address.
REQ-008 Port: Control_Register_Address  input  ADDR_WIDTH  jump/call target from the microinstruction.
REQ-009 Port: Next_State_Address_Select  input  3  next-address mode (REQ-014).
REQ-010 Port: Condition  input  1  branch condition for conditional mode.
REQ-011 Port: Stall  input  1  freezes the sequencer when high.
REQ-012 Port: Next_State_Address  output  ADDR_WIDTH  registered current microaddress driven to the microstore.
REQ-013 Port: Stack_Overflow, Stack_Underflow  output  1 each  sticky error flags; Stack_Level  output  clog2(STACK_DEPTH+1)  current stack occupancy.

Function
REQ-014 Select decoding at each rising edge (Stall low, Reset high); Inc = Next_State_Address+1:
- 000 Encoder: load Encoder_Address.
- 001 Fetch: load FETCH_ADDR.
- 010 Jump: load Control_Register_Address.
- 011 Increment: load Inc.
- 100 Call: push Inc, load Control_Register_Address.
- 101 Return: pop top entry, load it.
- 110 Branch: load Control_Register_Address if Condition=1, else Inc.
- 111 Hold: keep Next_State_Address.
REQ-015 Next_State_Address SHALL be a register; a select/data change SHALL affect it only at the next rising edge (latency 1 cycle), never combinationally.
REQ-016 Inc SHALL be computed modulo 2^ADDR_WIDTH; all-ones SHALL wrap to 0 with no flag.
REQ-017 Stack SHALL be LIFO of STACK_DEPTH entries; Stack_Level SHALL increment by 1 per successful push and decrement by 1 per successful pop.
REQ-018 Call with Stack_Level=STACK_DEPTH SHALL NOT push or jump; Next_State_Address holds; Stack_Overflow SHALL set to 1.
REQ-019 Return with Stack_Level=0 SHALL load FETCH_ADDR, leave the stack unchanged and set Stack_Underflow to 1.
REQ-020 Stack_Overflow and Stack_Underflow SHALL remain 1 until reset; no other event clears them.
REQ-021 Stall=1 SHALL take priority over every select code: Next_State_Address, stack contents, Stack_Level and flags unchanged.
REQ-022 Condition SHALL be ignored for every select code other than 110.
REQ-023 Call immediately followed by Return SHALL resume at the call address + 1 (wrapped per REQ-016).
REQ-024 Stack entries beyond Stack_Level are don't-care and SHALL never be driven to Next_State_Address.

Reset
REQ-025 When Reset is sampled low at a rising edge: Next_State_Address=RESET_ADDR, Stack_Level=0, Stack_Overflow=0, Stack_Underflow=0; Reset SHALL override Stall and all selects.
REQ-026 Reset asserted mid-call-chain SHALL discard all stacked addresses; a subsequent Return SHALL underflow per REQ-019.
REQ-027 Outputs before the first reset edge are undefined; nothing SHALL depend on power-up values.

Verification
REQ-028 Reset low one edge, then select 011 for 3 edges -> Next_State_Address 0,1,2,3; Stack_Level 0; flags 0.
REQ-029 At address 5, select 100 with Control_Register_Address=200 -> 200, Stack_Level 1; select 011 -> 201; select 101 -> 6, Stack_Level 0.
REQ-030 Defaults, 4 nested calls then a 5th call at address 40 -> address stays 40, Stack_Level 4, Stack_Overflow=1; 4 returns unwind in LIFO order; 5th return -> 1, Stack_Underflow=1.
REQ-031 Select 110, Control_Register_Address=300, at address 10: Condition=0 -> 11; Condition=1 -> 300; Stall=1 with select 000 -> address unchanged for every stalled cycle.
REQ-032 At address 511 (ADDR_WIDTH=9) select 011 -> 0, no flag; select 000 with Encoder_Address=77 -> 77; select 001 -> 1.
REQ-033 After 2 calls (Stack_Level 2) assert Reset low with Stall=1 -> address 0, Stack_Level 0, flags 0; next select 101 -> 1, Stack_Underflow=1.
